mem_access_unit: RTL and testbench

//  CPU-side initiator for the 28-bit-address / 32-bit-data MemoryModule port.

---
 rtl/mau_pkg.sv | 31 +++
 rtl/mau_wait_counter.sv | 37 +++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: default widths, FSM state
// encoding and the request-kind decode used on accept.
package mau_pkg;

    localparam int MAU_ADDR_W = 28;
    localparam int MAU_DATA_W = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_CLEAR = 2'd2
    } req_kind_e;

    // Clear outranks store, store outranks load.
    function automatic req_kind_e decode_kind(input logic clr, input logic we);
        if (clr) return REQ_CLEAR;
        if (we)  return REQ_STORE;
        return REQ_LOAD;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mau_wait_counter.sv
// Loadable down-counter that times the strobe windows of the access unit;
// done is high while the count is zero.
module mau_wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the MemoryModule port: load/store/clear with valid/ready.
// Optional MAU_RANGE_CHECK_EN: non-clear requests with req_addr >= MEM_DEPTH get resp_err.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W    = MAU_ADDR_W,
    parameter int DATA_W    = MAU_DATA_W,
    parameter int WR_LAT    = 1,
    parameter int RD_LAT    = 1,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_clr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              mem_rst,
    input  logic [DATA_W-1:0] mem_data1
);

    localparam int CNT_W = $clog2(max_int(WR_LAT, RD_LAT) + 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_rst_q, mem_rst_d;
    logic              cnt_load, cnt_done;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              out_of_range;

`ifdef MAU_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
    assign out_of_range = ({1'b0, req_addr} >= DEPTH_LIM);
`else
    // Depth only matters when range checking is built in.
    logic unused_depth;
    assign unused_depth = ^MEM_DEPTH;
    assign out_of_range = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d       = req_addr;
                    data_d       = req_wdata;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    case (decode_kind(req_clr, req_we))
                        REQ_CLEAR: state_d = ST_CLEAR;
                        REQ_STORE: state_d = ST_WRITE;
                        default:   state_d = ST_READ;
                    endcase
                    if (!req_clr && out_of_range) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end
                end
            end
            ST_CLEAR: state_d = ST_RESP;
            ST_WRITE: if (cnt_done) state_d = ST_RESP;
            ST_READ: begin
                if (cnt_done) begin
                    resp_rdata_d = mem_data1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Counter reloads on every state change; strobes follow the next state.
        cnt_load     = (state_d != state_q);
        cnt_load_val = (state_d == ST_WRITE) ? WR_LOAD :
                       (state_d == ST_READ)  ? RD_LOAD : '0;
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        mem_wr_d     = (state_d == ST_WRITE);
        mem_rd_d     = (state_d == ST_READ);
        mem_rst_d    = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_rst_q    <= mem_rst_d;
        end
    end

    mau_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (1'b1),
        .done    (cnt_done)
    );

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_rst     = mem_rst_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a fast instance (WR_LAT=RD_LAT=1) and a
// slow one (WR_LAT=2, RD_LAT=4), each attached to a small word-memory stub.
module tb_mem_access_unit;

`ifdef MAU_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        stub_clr = 1'b1;
    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic        req_clr     [2];
    logic [27:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_rdata  [2];
    logic        resp_err    [2];
    logic [27:0] mem_address [2];
    logic [31:0] mem_data    [2];
    logic        mem_wr      [2];
    logic        mem_rd      [2];
    logic        mem_rst     [2];
    logic [31:0] mem_data1   [2];

    logic [31:0] stub_mem [2][256];
    logic [31:0] ref_mem [int];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WR_LAT(1), .RD_LAT(1), .MEM_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_clr(req_clr[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .mem_address(mem_address[0]), .mem_data(mem_data[0]),
        .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]), .mem_rst(mem_rst[0]), .mem_data1(mem_data1[0])
    );

    mem_access_unit #(.WR_LAT(2), .RD_LAT(4), .MEM_DEPTH(DEPTH)) u_dut_slow (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_clr(req_clr[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .mem_address(mem_address[1]), .mem_data(mem_data[1]),
        .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]), .mem_rst(mem_rst[1]), .mem_data1(mem_data1[1])
    );

    // Word-memory stub: writes and clears land on the clock edge, reads are combinational.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (stub_clr || mem_rst[d]) begin
                for (int i = 0; i < 256; i++) stub_mem[d][i] <= '0;
            end else if (mem_wr[d]) begin
                stub_mem[d][mem_address[d][7:0]] <= mem_data[d];
            end
        end
    end
    assign mem_data1[0] = stub_mem[0][mem_address[0][7:0]];
    assign mem_data1[1] = stub_mem[1][mem_address[1][7:0]];

    function automatic int wr_lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int rd_lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete request/response exchange, checked against the expectations passed in.
    task automatic run_txn(input int d, input logic clr, input logic we, input logic [27:0] addr,
                           input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                           input logic exp_err, input string tag);
        int lat, nwr, nrd, nrst, exp_lat, guard;
        logic stable_ok, hold_ok;
        logic [31:0] held;
        exp_lat = exp_err ? 1 : (clr ? 2 : (we ? 1 + wr_lat(d) : 1 + rd_lat(d)));
        nwr = 0; nrd = 0; nrst = 0; stable_ok = 1'b1; hold_ok = 1'b1; guard = 0;
        while (!req_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".req_ready"}, req_ready[d], 1'b1);
        req_valid[d] = 1'b1; req_clr[d] = clr; req_we[d] = we;
        req_addr[d] = addr; req_wdata[d] = wd;
        @(negedge clk);
        req_valid[d] = 1'b0; req_clr[d] = 1'($urandom); req_we[d] = 1'($urandom);
        req_addr[d] = 28'($urandom); req_wdata[d] = $urandom;
        lat = 1;
        while (!resp_valid[d] && lat < 40) begin
            nwr += int'(mem_wr[d]); nrd += int'(mem_rd[d]); nrst += int'(mem_rst[d]);
            if ((mem_wr[d] || mem_rd[d] || mem_rst[d]) && mem_address[d] !== addr) stable_ok = 1'b0;
            if (mem_wr[d] && mem_data[d] !== wd) stable_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        nwr += int'(mem_wr[d]); nrd += int'(mem_rd[d]); nrst += int'(mem_rst[d]);
        if (mem_address[d] !== addr) stable_ok = 1'b0;
        held = resp_rdata[d];
        for (int h = 0; h < hold; h++) begin
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== held || req_ready[d] !== 1'b0 ||
                (mem_wr[d] | mem_rd[d] | mem_rst[d]) !== 1'b0 || mem_address[d] !== addr)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        resp_ready[d] = 1'b1;
        check({tag, ".rdata"}, resp_rdata[d], exp_rd);
        check({tag, ".err"}, resp_err[d], exp_err);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check({tag, ".n_wr"}, nwr, (!exp_err && !clr && we) ? wr_lat(d) : 0);
        check({tag, ".n_rd"}, nrd, (!exp_err && !clr && !we) ? rd_lat(d) : 0);
        check({tag, ".n_rst"}, nrst, (!exp_err && clr) ? 1 : 0);
        check({tag, ".addr_stable"}, stable_ok, 1'b1);
        check({tag, ".hold_stable"}, hold_ok, 1'b1);
        check({tag, ".resp_dropped"}, resp_valid[d], 1'b0);
        check({tag, ".ready_after_hs"}, req_ready[d], 1'b1);
    endtask

    typedef struct {
        logic        clr;
        logic        we;
        logic [27:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        clr, we, err, seen;
        logic [27:0] addr;
        logic [31:0] wd, exp;
        int          kind;

        vecs[0] = '{1'b0, 1'b1, 28'd5,   32'hA5A5_A5A5, 0, 32'h0,         "t1_store5"};
        vecs[1] = '{1'b0, 1'b0, 28'd5,   32'h0,         0, 32'hA5A5_A5A5, "t2_load5"};
        vecs[2] = '{1'b1, 1'b1, 28'd5,   32'h1234_5678, 0, 32'h0,         "t3_clear"};
        vecs[3] = '{1'b0, 1'b0, 28'd5,   32'h0,         0, 32'h0,         "t3_load5"};
        vecs[4] = '{1'b0, 1'b1, 28'd9,   32'hDEAD_BEEF, 3, 32'h0,         "t4_store_hold"};
        vecs[5] = '{1'b0, 1'b0, 28'd9,   32'h0,         3, 32'hDEAD_BEEF, "t4_load_hold"};
        vecs[6] = '{1'b0, 1'b1, 28'd0,   32'hFFFF_FFFF, 1, 32'h0,         "store_addr0"};
        vecs[7] = '{1'b0, 1'b0, 28'd0,   32'h0,         0, 32'hFFFF_FFFF, "load_addr0"};
        vecs[8] = '{1'b0, 1'b1, 28'd255, 32'h0BAD_CAFE, 0, 32'h0,         "store_addr255"};
        vecs[9] = '{1'b0, 1'b0, 28'd255, 32'h0,         2, 32'h0BAD_CAFE, "load_addr255"};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_clr[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        stub_clr = 1'b0;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_outputs%0d", d),
                  {req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d], mem_address[d],
                   mem_data[d], mem_wr[d], mem_rd[d], mem_rst[d]}, 128'(0));
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1 check("ready_low_at_release", req_ready[0], 1'b0);
        @(negedge clk);
        check("ready_after_release", req_ready[0], 1'b1);

        // Directed table on the fast instance; the model memory tracks it too.
        for (int v = 0; v < 10; v++) begin
            run_txn(0, vecs[v].clr, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].hold,
                    vecs[v].exp_rdata, 1'b0, vecs[v].name);
            if (vecs[v].clr) ref_mem.delete();
            else if (vecs[v].we) ref_mem[int'(vecs[v].addr)] = vecs[v].wdata;
        end

        // Random traffic against the model memory.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            clr  = (kind == 0);
            we   = (kind >= 1 && kind <= 4);
            addr = (RANGE_EN && $urandom_range(0, 4) == 0) ? 28'($urandom_range(240, 320))
                                                          : 28'($urandom_range(0, 15));
            wd   = $urandom;
            err  = RANGE_EN && !clr && (int'(addr) >= DEPTH);
            exp  = 32'h0;
            if (!clr && !we && !err && ref_mem.exists(int'(addr))) exp = ref_mem[int'(addr)];
            run_txn(0, clr, we, addr, wd, int'($urandom_range(0, 2)), exp, err,
                    $sformatf("rand%0d", n));
            if (clr) ref_mem.delete();
            else if (we && !err) ref_mem[int'(addr)] = wd;
        end

`ifdef MAU_RANGE_CHECK_EN
        run_txn(0, 1'b0, 1'b0, 28'd300, 32'h0, 1, 32'h0, 1'b1, "t6_load300");
        run_txn(0, 1'b0, 1'b1, 28'd256, 32'h5555_AAAA, 0, 32'h0, 1'b1, "store256");
        run_txn(0, 1'b1, 1'b0, 28'd300, 32'h0, 0, 32'h0, 1'b0, "clear_addr300");
`endif

        // Slow instance: multi-cycle strobe windows and reset mid-read.
        run_txn(1, 1'b0, 1'b1, 28'd2, 32'h0BAD_F00D, 0, 32'h0, 1'b0, "slow_store");
        run_txn(1, 1'b0, 1'b0, 28'd2, 32'h0, 1, 32'h0BAD_F00D, 1'b0, "slow_load");

        req_valid[1] = 1'b1; req_clr[1] = 1'b0; req_we[1] = 1'b0; req_addr[1] = 28'd2;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("t5_rd_active", mem_rd[1], 1'b1);
        #2 rst_n[1] = 1'b0;
        #1;
        check("t5_rd_drops", mem_rd[1], 1'b0);
        check("t5_no_resp", resp_valid[1], 1'b0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        #1 check("t5_ready_low", req_ready[1], 1'b0);
        @(negedge clk);
        check("t5_ready_high", req_ready[1], 1'b1);
        seen = 1'b0;
        repeat (6) begin
            seen = seen | resp_valid[1] | mem_rd[1] | mem_wr[1] | mem_rst[1];
            @(negedge clk);
        end
        check("t5_quiet_after_reset", seen, 1'b0);
        run_txn(1, 1'b0, 1'b0, 28'd2, 32'h0, 0, 32'h0BAD_F00D, 1'b0, "slow_reload");
        run_txn(1, 1'b1, 1'b0, 28'd2, 32'h0, 0, 32'h0, 1'b0, "slow_clear");
        run_txn(1, 1'b0, 1'b0, 28'd2, 32'h0, 0, 32'h0, 1'b0, "slow_load_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
